cpu_control_unit: RTL
=====================

// Module: cpu_control_unit
// PURPOSE
//   Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU; sits directly upstream of the ALU.
//   Fetches instruction bytes over a req/ack memory port and decodes them. Drives the ALU opcode,
//   register-file read/write addresses and the writeback strobe. Holds the PC and the architectural
//   zero flag, captured from the ALU's zf output.
// PARAMETERS
//   ADDR_W    8   instruction address width, 1..8; jump targets use imm[ADDR_W-1:0]
//   RESET_PC  0   PC value loaded on reset
// PORTS
//   clk         in   1       single clock, rising edge
//   rst_n       in   1       synchronous reset, active-low
//   imem_req    out  1       fetch request; held high with stable imem_addr until imem_ack
//   imem_addr   out  ADDR_W  fetch address (= pc)
//   imem_ack    in   1       rdata valid this cycle; ignored while imem_req=0
//   imem_rdata  in   8       instruction/immediate byte
//   alu_opcode  out  3       ALU opcode; 3'b111 (undefined, ALU y=0) outside ALU execute
//   alu_zf      in   1       ALU zero flag for the current alu_opcode/operands
//   rf_ra_addr  out  2       register-file read A = IR[4:3] (rd); feeds ALU a
//   rf_rb_addr  out  2       register-file read B = IR[2:1] (rs); feeds ALU b
//   rf_we       out  1       one-cycle write strobe
//   rf_waddr    out  2       write address = IR[4:3]
//   rf_wsel     out  1       write data select: 0 = ALU y, 1 = imm
//   imm         out  8       immediate register
//   pc          out  ADDR_W  program counter
//   zflag       out  1       architectural zero flag
//   halted      out  1       high in HALT state
// BEHAVIOUR
//   Encoding: IR[7:5] op, IR[4:3] rd, IR[2:1] rs, IR[0] ignored.
//     ADD=000 rd<=rd+rs; AND=001 rd<=rd&rs; NOT=010 rd<=~rd.
//     LDI=011 rd<=next byte; JZ=100 if zflag pc<=next byte; JMP=101 pc<=next byte;
//     NOP=110; HLT=111.
//   States: FETCH, DECODE, FETCH_IMM, EXEC, HALT.
//   Reset, at the first clk edge with rst_n=0: state=FETCH, pc=RESET_PC, IR=0, imm=0, zflag=0,
//     halted=0. Any in-flight fetch is abandoned and an ack in that cycle is discarded.
//     Reset overrides every other event, including HALT.
//   FETCH: imem_req=1, imem_addr=pc. On ack: IR<=rdata, pc<=pc+1, go to DECODE.
//     Without ack the state and address hold (any number of wait cycles).
//   DECODE, no memory access:
//     ADD/AND/NOT -> EXEC; LDI/JZ/JMP -> FETCH_IMM; NOP -> FETCH; HLT -> HALT.
//   FETCH_IMM: same handshake as FETCH. On ack: imm<=rdata, pc<=pc+1, go to EXEC.
//   EXEC, one cycle, then FETCH:
//     ALU ops: alu_opcode=IR[7:5], rf_we=1, rf_wsel=0, zflag<=alu_zf.
//     LDI: rf_we=1, rf_wsel=1; zflag unchanged.
//     JZ: pc<=imm if zflag else unchanged. JMP: pc<=imm. rf_we=0 for both.
//   HALT: imem_req=0, rf_we=0, halted=1; exits only via reset.
//   Only ALU ops write zflag; NOT writes zflag from ~rd.
//   Latency with a zero-wait memory (ack in the same cycle as req):
//     ALU op 3 cycles, LDI/JZ/JMP 4, NOP 2.
//   pc increments modulo 2^ADDR_W (all-ones wraps to 0). A jump overrides the increment.
//   rf_we and alu_opcode are decoded from state/IR. Outside EXEC: rf_we=0, alu_opcode=3'b111.
// TESTING
//   Reset: rst_n=0 for 2 cycles, then 1 -> pc=0, imem_req=1, imem_addr=0, rf_we=0, zflag=0,
//     halted=0.
//   LDI r1,0x05 (bytes 0x68,0x05), zero-wait -> rf_we pulses in cycle 4 with rf_waddr=1,
//     rf_wsel=1, imm=0x05; pc=2; zflag unchanged.
//   ADD r1,r2 (0x0C), alu_zf=1 in EXEC -> alu_opcode=000, ra=1, rb=2, rf_we=1, rf_wsel=0,
//     then zflag=1.
//   JZ 0x40 (0x80,0x40): zflag=1 -> pc=0x40 next fetch; zflag=0 -> pc=0x02.
//     JMP 0x10 (0xA0,0x10) -> pc=0x10.
//   Wait states: ack delayed 3 cycles -> req and addr held stable, no state/pc change.
//     With pc=0xFF, NOP fetch -> pc=0x00.
//   HLT (0xE0) -> halted=1, imem_req=0 indefinitely. rst_n=0 during a delayed fetch -> request
//     abandoned, restart at pc=0.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Owns PC, IR, immediate and zero flag; drives ALU opcode and RF strobes.
module cpu_control_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic [2:0]        alu_opcode,
  input  logic              alu_zf,
  output logic [1:0]        rf_ra_addr,
  output logic [1:0]        rf_rb_addr,
  output logic              rf_we,
  output logic [1:0]        rf_waddr,
  output logic              rf_wsel,
  output logic [7:0]        imm,
  output logic [ADDR_W-1:0] pc,
  output logic              zflag,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_EXEC,
    S_HALT
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_LDI = 3'b011;
  localparam logic [2:0] OP_JZ  = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        imm_q, imm_d;
  logic              zf_q, zf_d;

  logic [2:0]        op;
  logic              is_alu;
  logic              in_exec;
  logic [ADDR_W-1:0] pc_inc;
  logic              unused_ir0;

  assign op         = ir_q[7:5];
  assign is_alu     = (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  assign in_exec    = (state_q == S_EXEC);
  assign pc_inc     = pc_q + ADDR_W'(1);
  assign unused_ir0 = ir_q[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      imm_q   <= '0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      zf_q    <= zf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    zf_d    = zf_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_inc;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LDI, OP_JZ, OP_JMP: state_d = S_FETCH_IMM;
          OP_NOP:                state_d = S_FETCH;
          OP_HLT:                state_d = S_HALT;
          default:               state_d = S_EXEC;
        endcase
      end
      S_FETCH_IMM: begin
        if (imem_ack) begin
          imm_d   = imem_rdata;
          pc_d    = pc_inc;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_alu) zf_d = alu_zf;
        // a taken jump replaces the already-incremented pc
        if ((op == OP_JMP) || ((op == OP_JZ) && zf_q))
          pc_d = imm_q[ADDR_W-1:0];
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign imem_req   = (state_q == S_FETCH) || (state_q == S_FETCH_IMM);
  assign imem_addr  = pc_q;
  assign alu_opcode = (in_exec && is_alu) ? op : 3'b111;
  assign rf_ra_addr = ir_q[4:3];
  assign rf_rb_addr = ir_q[2:1];
  assign rf_we      = in_exec && (is_alu || (op == OP_LDI));
  assign rf_waddr   = ir_q[4:3];
  assign rf_wsel    = (op == OP_LDI);
  assign imm        = imm_q;
  assign pc         = pc_q;
  assign zflag      = zf_q;
  assign halted     = (state_q == S_HALT);

endmodule
